// File: rtl/ahb_slave_arbiter_gen.sv
// AHB slave-side arbiter: picks one owner among MASTER_NUM requesters
// (fixed, dynamic-priority or round-robin), tracks the owner's burst length
// and raises hlast on the final beat so ownership can hand over without an
// idle cycle.
module ahb_slave_arbiter_gen #(
   parameter int MASTER_NUM = 4,
   parameter int PRIOR_BIT  = 2,
   parameter int ARB_MODE   = 0
) (
   input  logic                                   hclk,
   input  logic                                   hreset,
   input  logic [MASTER_NUM-1:0]                  hreq,
   input  logic [2:0]                             hburst,
   input  logic                                   hwait,
   input  logic [MASTER_NUM-1:0][PRIOR_BIT-1:0]   hprior,
   output logic [MASTER_NUM-1:0]                  hgrant,
   output logic                                   hsel,
   output logic [$clog2(MASTER_NUM)-1:0]          hmaster,
   output logic                                   hlast
);

   localparam int MW = $clog2(MASTER_NUM);

   localparam logic [2:0] B_SINGLE = 3'd0;
   localparam logic [2:0] B_INCR   = 3'd1;
   localparam logic [2:0] B_WRAP4  = 3'd2;
   localparam logic [2:0] B_INCR4  = 3'd3;
   localparam logic [2:0] B_WRAP8  = 3'd4;
   localparam logic [2:0] B_INCR8  = 3'd5;

   typedef enum logic {IDLE, OWN} state_t;

   state_t                state_q, state_d;
   logic [MASTER_NUM-1:0] grant_q, grant_d;
   logic [2:0]            burst_q, burst_d;
   logic [3:0]            cnt_q,   cnt_d;
   logic [MW-1:0]         ptr_q,   ptr_d;

   logic [MW-1:0]         win_fix, win_dyn, win_rr, win;
   logic [MW-1:0]         ptr_nxt;
   logic [3:0]            lim_m1;
   logic                  arb_pt;
   logic                  any_req;

   assign any_req = |hreq;

   // Candidate winners for each policy; the parameter picks one at the end.
   always_comb begin
      logic          f_fix, f_dyn, f_rr;
      logic [PRIOR_BIT-1:0] best;
      logic [MW:0]   sum;
      logic [MW-1:0] idx;
      win_fix = '0;
      win_dyn = '0;
      win_rr  = '0;
      f_fix   = 1'b0;
      f_dyn   = 1'b0;
      f_rr    = 1'b0;
      best    = '0;
      sum     = '0;
      idx     = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (hreq[i] && !f_fix) begin
            win_fix = MW'(i);
            f_fix   = 1'b1;
         end
         // strict '>' keeps ties on the lowest index
         if (hreq[i] && (!f_dyn || hprior[i] > best)) begin
            win_dyn = MW'(i);
            best    = hprior[i];
            f_dyn   = 1'b1;
         end
      end
      for (int k = 0; k < MASTER_NUM; k++) begin
         sum = {1'b0, ptr_q} + (MW+1)'(k);
         if (sum >= (MW+1)'(MASTER_NUM)) sum = sum - (MW+1)'(MASTER_NUM);
         idx = sum[MW-1:0];
         if (hreq[idx] && !f_rr) begin
            win_rr = idx;
            f_rr   = 1'b1;
         end
      end
      case (ARB_MODE)
         1:       win = win_dyn;
         2:       win = win_rr;
         default: win = win_fix;
      endcase
   end

   // Round-robin pointer successor: one past the winner, wrapping.
   always_comb begin
      logic [MW:0] s;
      s = {1'b0, win} + (MW+1)'(1);
      if (s >= (MW+1)'(MASTER_NUM)) s = s - (MW+1)'(MASTER_NUM);
      ptr_nxt = s[MW-1:0];
   end

   // Beat limit minus one for the captured burst type.
   always_comb begin
      case (burst_q)
         B_SINGLE, B_INCR: lim_m1 = 4'd0;
         B_WRAP4, B_INCR4: lim_m1 = 4'd3;
         B_WRAP8, B_INCR8: lim_m1 = 4'd7;
         default:          lim_m1 = 4'd15;
      endcase
   end

   // Output decode; INCR ends when the owner drops its request.
   always_comb begin
      hsel    = |grant_q;
      hgrant  = grant_q & {MASTER_NUM{~hwait}};
      hmaster = '0;
      for (int i = 0; i < MASTER_NUM; i++)
         if (grant_q[i]) hmaster = hmaster | MW'(i);
      if (!hsel)
         hlast = 1'b0;
      else if (burst_q == B_INCR)
         hlast = ~|(hreq & grant_q);
      else
         hlast = (cnt_q == lim_m1);
   end

   assign arb_pt = (state_q == IDLE) || (hlast && !hwait);

   // Next-state: grant at arbitration points, otherwise count unstalled beats.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      if (arb_pt) begin
         cnt_d = 4'd0;
         if (any_req) begin
            state_d = OWN;
            grant_d = '0;
            grant_d[win] = 1'b1;
            burst_d = hburst;
            if (ARB_MODE == 2) ptr_d = ptr_nxt;
         end else begin
            state_d = IDLE;
            grant_d = '0;
         end
      end else if (hsel && !hwait) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= IDLE;
         grant_q <= '0;
         burst_q <= B_SINGLE;
         cnt_q   <= 4'd0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule
